// File: rtl/tow_pkg.sv
// rtl/tow_pkg.sv - shared types and constants for the tug-of-war scorer
//
// Purpose : state encoding, rope geometry and the position-to-LED decode
//           used by tow_scorer.
// Contents: state_e     - round state (idle / play / win)
//           LED_W       - rope LED count
//           POS_W       - rope position width
//           CENTER_POS  - start-of-round position
//           POS_MAX     - left end position (right end is 0)
//           pos_onehot  - position to one-hot LED vector
package tow_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_WIN  = 2'd2
    } state_e;

    localparam int LED_W = 7;
    localparam int POS_W = 3;

    localparam logic [POS_W-1:0] CENTER_POS = 3'd3;
    localparam logic [POS_W-1:0] POS_MAX    = 3'd6;
    localparam logic [POS_W-1:0] POS_MIN    = 3'd0;

    // Bit 6 is the left end, bit 0 the right end, so the position value is
    // directly the bit index.
    function automatic logic [LED_W-1:0] pos_onehot(input logic [POS_W-1:0] pos);
        return LED_W'(1) << pos;
    endfunction

endpackage

// File: rtl/rise_detect.sv
// rtl/rise_detect.sv - rising-edge detector for one player button
//
// Purpose : flags the first cycle a button level is seen high.
// Ports   : clk    - system clock
//           rst    - synchronous active-high reset
//           i_btn  - synchronised/debounced button level
//           o_rise - high for the cycle in which i_btn rises
module rise_detect (
    input  logic clk,
    input  logic rst,
    input  logic i_btn,
    output logic o_rise
);

    logic r_btn_q;

    // Resetting the history to 1 means a button already held when reset
    // releases is treated as "was high", so it cannot score a press.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_btn_q <= 1'b1;
        end else begin
            r_btn_q <= i_btn;
        end
    end

    assign o_rise = i_btn & ~r_btn_q;

endmodule

// File: rtl/tow_scorer.sv
// rtl/tow_scorer.sv - tug-of-war rope position scorer with winner blink
//
// Purpose : turns left/right button presses into a one-hot rope position,
//           detects the winner and blinks the winning end LED until the
//           next round is started.
// Ports   : clk        - system clock
//           rst        - synchronous active-high reset
//           start      - one-cycle pulse, begin/restart a round at centre
//           play_en    - level, presses counted only when high
//           btn_l      - left player button level
//           btn_r      - right player button level
//           score      - one-hot rope position, bit 6 = left end
//           round_over - high while a winner is being shown
//           winner_l   - left player won the round
//           winner_r   - right player won the round
module tow_scorer
    import tow_pkg::*;
#(
    parameter int LOCKOUT      = 16,
    parameter int BLINK_PERIOD = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             play_en,
    input  logic             btn_l,
    input  logic             btn_r,
    output logic [LED_W-1:0] score,
    output logic             round_over,
    output logic             winner_l,
    output logic             winner_r
);

    localparam int LO_W = $clog2(LOCKOUT + 1);
    localparam int BL_W = $clog2(BLINK_PERIOD + 1);

    localparam logic [LO_W-1:0] LO_LOAD = LO_W'(LOCKOUT);
    localparam logic [BL_W-1:0] BL_LAST = BL_W'(BLINK_PERIOD - 1);

    state_e           r_state;
    logic [POS_W-1:0] r_pos;
    logic [LO_W-1:0]  r_lockout;
    logic [BL_W-1:0]  r_blink_cnt;
    logic             r_blink_on;
    logic             r_round_over;
    logic             r_winner_l;
    logic             r_winner_r;

    logic w_rise_l;
    logic w_rise_r;
    logic w_press_ok;

    rise_detect u_rise_l (
        .clk    (clk),
        .rst    (rst),
        .i_btn  (btn_l),
        .o_rise (w_rise_l)
    );

    rise_detect u_rise_r (
        .clk    (clk),
        .rst    (rst),
        .i_btn  (btn_r),
        .o_rise (w_rise_r)
    );

    // Exactly one rise is a press; a simultaneous pair is a tie and is
    // dropped without loading the lockout.
    assign w_press_ok = play_en && (r_lockout == '0) && (w_rise_l ^ w_rise_r);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_pos        <= CENTER_POS;
            r_lockout    <= '0;
            r_blink_cnt  <= '0;
            r_blink_on   <= 1'b1;
            r_round_over <= 1'b0;
            r_winner_l   <= 1'b0;
            r_winner_r   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state   <= ST_PLAY;
                        r_pos     <= CENTER_POS;
                        r_lockout <= '0;
                    end
                end

                ST_PLAY: begin
                    if (start) begin
                        // Restart wins over any press sampled this cycle.
                        r_pos     <= CENTER_POS;
                        r_lockout <= '0;
                    end else begin
                        // Lockout keeps running even while play_en is low.
                        if (r_lockout != '0) begin
                            r_lockout <= r_lockout - 1'b1;
                        end
                        if (w_press_ok) begin
                            r_lockout <= LO_LOAD;
                            if (w_rise_l) begin
                                if (r_pos == POS_MAX) begin
                                    r_state      <= ST_WIN;
                                    r_winner_l   <= 1'b1;
                                    r_round_over <= 1'b1;
                                    r_blink_cnt  <= '0;
                                    r_blink_on   <= 1'b1;
                                end else begin
                                    r_pos <= r_pos + 1'b1;
                                end
                            end else begin
                                if (r_pos == POS_MIN) begin
                                    r_state      <= ST_WIN;
                                    r_winner_r   <= 1'b1;
                                    r_round_over <= 1'b1;
                                    r_blink_cnt  <= '0;
                                    r_blink_on   <= 1'b1;
                                end else begin
                                    r_pos <= r_pos - 1'b1;
                                end
                            end
                        end
                    end
                end

                ST_WIN: begin
                    if (start) begin
                        r_state      <= ST_PLAY;
                        r_pos        <= CENTER_POS;
                        r_lockout    <= '0;
                        r_blink_cnt  <= '0;
                        r_blink_on   <= 1'b1;
                        r_round_over <= 1'b0;
                        r_winner_l   <= 1'b0;
                        r_winner_r   <= 1'b0;
                    end else begin
                        // Each phase lasts BLINK_PERIOD cycles.
                        if (r_blink_cnt == BL_LAST) begin
                            r_blink_cnt <= '0;
                            r_blink_on  <= ~r_blink_on;
                        end else begin
                            r_blink_cnt <= r_blink_cnt + 1'b1;
                        end
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                    r_pos   <= CENTER_POS;
                end
            endcase
        end
    end

    // Pure decode of registered state; button inputs never reach score.
    assign score      = ((r_state == ST_WIN) && !r_blink_on) ? '0 : pos_onehot(r_pos);
    assign round_over = r_round_over;
    assign winner_l   = r_winner_l;
    assign winner_r   = r_winner_r;

endmodule
